// File: rtl/branch_feedback_unit.sv
// branch_feedback_unit
// Closes the branch-prediction loop between EX and the PC stage. ID pushes
// the fetch-time prediction of every control-transfer instruction into an
// in-order queue; when EX resolves the oldest branch, the entry is popped,
// compared against the real outcome, and a registered one-cycle training /
// redirect pulse is driven towards the GHR/PHT/BTB and next-PC mux.
//
// Optional feature macro: BRANCH_STAT_EN
//   defined   -> saturating 32-bit resolved-branch and misprediction counters
//   undefined -> stat_branch_cnt / stat_miss_cnt tied to 0, no counter logic
module branch_feedback_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 10,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ADDR_WIDTH-1:0]         push_pc,
    input  logic                          push_pred_taken,
    input  logic [ADDR_WIDTH-1:0]         push_pred_target,
    input  logic [GHR_WIDTH-1:0]          push_pht_index,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic                          res_taken,
    input  logic                          res_is_jump,
    input  logic [ADDR_WIDTH-1:0]         res_target,
    output logic                          is_branch_out,
    output logic                          is_jump_out,
    output logic                          is_taken_out,
    output logic                          is_miss_out,
    output logic [GHR_WIDTH-1:0]          last_pht_index_out,
    output logic [ADDR_WIDTH-1:0]         inst_pc_out,
    output logic [ADDR_WIDTH-1:0]         target_out,
    output logic [$clog2(DEPTH):0]        count_out,
    output logic [31:0]                   stat_branch_cnt,
    output logic [31:0]                   stat_miss_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Prediction storage, one slot per in-flight control-transfer instruction
    logic [ADDR_WIDTH-1:0] pc_mem      [DEPTH];
    logic                  taken_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] target_mem  [DEPTH];
    logic [GHR_WIDTH-1:0]  index_mem   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic                  push_fire;
    logic                  pop_fire;
    logic                  pulse_fire;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  head_pred_taken;
    logic [ADDR_WIDTH-1:0] head_pred_target;
    logic [GHR_WIDTH-1:0]  head_index;
    logic                  pop_miss;
    logic [ADDR_WIDTH-1:0] pop_target;

    // Handshake readiness depends only on stored occupancy, never on the
    // same-cycle activity of the other side
    assign push_ready = (count != FULL_COUNT);
    assign res_ready  = (count != '0);
    assign count_out  = count;

    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = res_valid && res_ready;
    assign pulse_fire = pop_fire && !flush;

    assign head_pc          = pc_mem[rd_ptr];
    assign head_pred_taken  = taken_mem[rd_ptr];
    assign head_pred_target = target_mem[rd_ptr];
    assign head_index       = index_mem[rd_ptr];

    // Compare the oldest prediction with the resolved outcome and pick the
    // redirect target (fall-through PC when a predicted-taken branch falls through)
    always_comb begin
        pop_miss   = (head_pred_taken != res_taken) ||
                     (head_pred_taken && res_taken && (head_pred_target != res_target));
        pop_target = res_target;
        if (pop_miss && !res_taken) begin
            pop_target = head_pc + ADDR_WIDTH'(4);
        end
    end

    // Capture the pushed prediction; a dropped push writes a slot that the
    // pointer never advances over, so it is simply overwritten later
    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[wr_ptr]     <= push_pc;
            taken_mem[wr_ptr]  <= push_pred_taken;
            target_mem[wr_ptr] <= push_pred_target;
            index_mem[wr_ptr]  <= push_pht_index;
        end
    end

    // Pointer and occupancy bookkeeping; flush or a miss discards every
    // queued entry and any same-cycle push
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush || (pop_fire && pop_miss)) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered training/redirect pulse, one cycle per non-flushed pop;
    // the data fields hold their last value between pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_branch_out      <= 1'b0;
            is_jump_out        <= 1'b0;
            is_taken_out       <= 1'b0;
            is_miss_out        <= 1'b0;
            last_pht_index_out <= '0;
            inst_pc_out        <= '0;
            target_out         <= '0;
        end else begin
            is_branch_out <= pulse_fire;
            is_jump_out   <= pulse_fire && res_is_jump;
            is_taken_out  <= pulse_fire && res_taken;
            is_miss_out   <= pulse_fire && pop_miss;
            if (pulse_fire) begin
                last_pht_index_out <= head_index;
                inst_pc_out        <= head_pc;
                target_out         <= pop_target;
            end
        end
    end

`ifdef BRANCH_STAT_EN
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    // Saturating performance counters; they survive flush and clear on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (pulse_fire && (branch_cnt != 32'hFFFF_FFFF)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (pulse_fire && pop_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign stat_branch_cnt = branch_cnt;
    assign stat_miss_cnt   = miss_cnt;
`else
    assign stat_branch_cnt = 32'd0;
    assign stat_miss_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_feedback_unit.sv
// tb_branch_feedback_unit
// Scoreboard bench: the stimulus process keeps a queue-level model of the
// prediction queue and pushes every expected pulse; a negedge monitor pops
// and compares whenever the DUT presents (or should present) a pulse.
module tb_branch_feedback_unit;

    localparam int AW    = 32;
    localparam int GW    = 10;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [AW-1:0] push_pc;
    logic          push_pred_taken;
    logic [AW-1:0] push_pred_target;
    logic [GW-1:0] push_pht_index;
    logic          res_valid;
    logic          res_ready;
    logic          res_taken;
    logic          res_is_jump;
    logic [AW-1:0] res_target;
    logic          is_branch_out;
    logic          is_jump_out;
    logic          is_taken_out;
    logic          is_miss_out;
    logic [GW-1:0] last_pht_index_out;
    logic [AW-1:0] inst_pc_out;
    logic [AW-1:0] target_out;
    logic [CW-1:0] count_out;
    logic [31:0]   stat_branch_cnt;
    logic [31:0]   stat_miss_cnt;

    typedef struct {
        logic [AW-1:0] pc;
        logic          pred_taken;
        logic [AW-1:0] pred_target;
        logic [GW-1:0] idx;
    } entry_t;

    typedef struct {
        logic          jump;
        logic          taken;
        logic          miss;
        logic [GW-1:0] idx;
        logic [AW-1:0] pc;
        logic [AW-1:0] target;
    } pulse_t;

    entry_t      model_q[$];
    pulse_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;
    longint      model_branches = 0;
    longint      model_misses = 0;
    bit          mon_en = 1'b0;

    branch_feedback_unit #(
        .ADDR_WIDTH(AW),
        .GHR_WIDTH (GW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .push_valid        (push_valid),
        .push_ready        (push_ready),
        .push_pc           (push_pc),
        .push_pred_taken   (push_pred_taken),
        .push_pred_target  (push_pred_target),
        .push_pht_index    (push_pht_index),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_taken         (res_taken),
        .res_is_jump       (res_is_jump),
        .res_target        (res_target),
        .is_branch_out     (is_branch_out),
        .is_jump_out       (is_jump_out),
        .is_taken_out      (is_taken_out),
        .is_miss_out       (is_miss_out),
        .last_pht_index_out(last_pht_index_out),
        .inst_pc_out       (inst_pc_out),
        .target_out        (target_out),
        .count_out         (count_out),
        .stat_branch_cnt   (stat_branch_cnt),
        .stat_miss_cnt     (stat_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model
    task automatic applyStimulus(input bit rst_v, input bit flush_v,
                                 input bit pv, input logic [AW-1:0] pc, input bit pt,
                                 input logic [AW-1:0] ptgt, input logic [GW-1:0] idx,
                                 input bit rv, input bit tk, input bit jp,
                                 input logic [AW-1:0] rtgt);
        entry_t e;
        pulse_t p;
        bit     can_push;
        bit     can_pop;
        rst              = rst_v;
        flush            = flush_v;
        push_valid       = pv;
        push_pc          = pc;
        push_pred_taken  = pt;
        push_pred_target = ptgt;
        push_pht_index   = idx;
        res_valid        = rv;
        res_taken        = tk;
        res_is_jump      = jp;
        res_target       = rtgt;
        @(posedge clk);
        can_push = (model_q.size() < DEPTH);
        can_pop  = rv && (model_q.size() > 0);
        if (!rst_v) begin
            model_q.delete();
            exp_q.delete();
            model_branches = 0;
            model_misses   = 0;
        end else if (flush_v) begin
            model_q.delete();
        end else begin
            if (can_pop) begin
                e = model_q.pop_front();
                p.jump  = jp;
                p.taken = tk;
                p.idx   = e.idx;
                p.pc    = e.pc;
                if (e.pred_taken != tk)
                    p.miss = 1'b1;
                else if (tk && (e.pred_target != rtgt))
                    p.miss = 1'b1;
                else
                    p.miss = 1'b0;
                if (p.miss && !tk)
                    p.target = e.pc + 32'd4;
                else
                    p.target = rtgt;
                exp_q.push_back(p);
                model_branches++;
                if (p.miss) begin
                    model_misses++;
                    model_q.delete();
                end
            end
            if (pv && can_push && !(can_pop && p.miss)) begin
                e.pc          = pc;
                e.pred_taken  = pt;
                e.pred_target = ptgt;
                e.idx         = idx;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doPush(input logic [AW-1:0] pc, input bit pt, input logic [AW-1:0] ptgt,
                          input logic [GW-1:0] idx);
        applyStimulus(1, 0, 1, pc, pt, ptgt, idx, 0, 0, 0, 0);
    endtask

    task automatic doPop(input bit tk, input logic [AW-1:0] rtgt);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, tk, 0, rtgt);
    endtask

    // Compare everything the DUT presents this cycle against the scoreboard
    task automatic checkOutput();
        pulse_t p;
        if (is_branch_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse actual=1 expected=0 at %0t", $time);
            end else begin
                p = exp_q.pop_front();
                checkValue("is_jump", is_jump_out, p.jump);
                checkValue("is_taken", is_taken_out, p.taken);
                checkValue("is_miss", is_miss_out, p.miss);
                checkValue("pht_index", last_pht_index_out, p.idx);
                checkValue("inst_pc", inst_pc_out, p.pc);
                checkValue("target", target_out, p.target);
            end
        end else begin
            if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_pulse actual=0 expected=1 at %0t", $time);
                exp_q.delete();
            end
            checkValue("idle_flags", {is_jump_out, is_taken_out, is_miss_out}, 3'b000);
        end
        checkValue("count", count_out, model_q.size());
        checkValue("push_ready", push_ready, model_q.size() < DEPTH);
        checkValue("res_ready", res_ready, model_q.size() > 0);
`ifdef BRANCH_STAT_EN
        checkValue("stat_branch", stat_branch_cnt, model_branches);
        checkValue("stat_miss", stat_miss_cnt, model_misses);
`else
        checkValue("stat_branch", stat_branch_cnt, 0);
        checkValue("stat_miss", stat_miss_cnt, 0);
`endif
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge
    always @(negedge clk) begin
        if (mon_en) checkOutput();
    end

    initial begin
        logic [AW-1:0] tgts [4];
        tgts[0] = 32'h2000;
        tgts[1] = 32'h3000;
        tgts[2] = 32'h4000;
        tgts[3] = 32'hFFFF_FFFC;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("reset_is_branch", is_branch_out, 0);
        checkValue("reset_target", target_out, 0);
        checkValue("reset_pc", inst_pc_out, 0);
        checkValue("reset_index", last_pht_index_out, 0);
        checkValue("reset_push_ready", push_ready, 1);
        checkValue("reset_res_ready", res_ready, 0);
        mon_en = 1'b1;
        idle();

        $display("[TB] correct taken prediction");
        doPush(32'h1000, 1, 32'h2000, 10'h15);
        doPop(1, 32'h2000);
        idle();

        $display("[TB] direction miss with same-cycle push");
        doPush(32'h1000, 1, 32'h2000, 10'h01);
        doPush(32'h1010, 0, 32'h0, 10'h02);
        doPush(32'h1020, 1, 32'h2400, 10'h03);
        doPush(32'h1030, 0, 32'h0, 10'h04);
        applyStimulus(1, 0, 1, 32'h1040, 0, 0, 10'h05, 1, 0, 0, 32'h2000);
        idle();
        doPop(1, 32'h2000);
        idle();

        $display("[TB] target miss");
        doPush(32'h1000, 1, 32'h2000, 10'h07);
        doPop(1, 32'h3000);
        idle();

        $display("[TB] full queue and pointer wrap");
        for (int i = 0; i < DEPTH; i++) doPush(32'h5000 + 32'(i * 4), 1, 32'h2000, 10'(i));
        applyStimulus(1, 0, 1, 32'h6000, 1, 32'h2000, 10'h3F, 1, 1, 0, 32'h2000);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, 0, 1, 32'h7000 + 32'(i * 4), 1, 32'h2000, 10'(i + 16), 1, 1, 0, 32'h2000);
        for (int i = 0; i < DEPTH; i++) doPop(1, 32'h2000);
        idle();

        $display("[TB] flush with pop, resolve on empty queue");
        doPush(32'h8000, 0, 0, 10'h2A);
        doPush(32'h8004, 1, 32'h2000, 10'h2B);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        doPop(0, 0);
        doPop(1, 32'h2000);
        idle();

        $display("[TB] jump resolution and stats mix");
        doPush(32'h9000, 1, 32'h2000, 10'h11);
        doPush(32'h9004, 0, 0, 10'h12);
        doPush(32'h9008, 1, 32'h3000, 10'h13);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h2000);
        doPop(0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h4000);
        idle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            bit r_v, f_v, pv, pt, rv, tk, jp;
            r_v = ($urandom_range(0, 199) != 0);
            f_v = ($urandom_range(0, 39) == 0);
            pv  = ($urandom_range(0, 9) < 6);
            pt  = $urandom_range(0, 1);
            rv  = ($urandom_range(0, 9) < 5);
            jp  = ($urandom_range(0, 7) == 0);
            tk  = jp ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus(r_v, f_v, pv,
                          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC),
                          pt, tgts[$urandom_range(0, 2)], 10'($urandom()),
                          rv, tk, jp, tgts[$urandom_range(0, 3)]);
        end

        $display("[TB] reset mid-operation");
        doPush(32'hA000, 1, 32'h2000, 10'h31);
        doPush(32'hA004, 1, 32'h2000, 10'h32);
        doPop(1, 32'h2000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h2000);
        idle();
        idle();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
